// File: rtl/synchronous_counter.sv
// synchronous_counter: free-running modulo-(MAX_COUNT+1) counter with terminal count and wrap pulse.
// Defining SYNCHRONOUS_COUNTER_GRAY_EN adds a registered Gray-code output count_gray.
module synchronous_counter #(
  parameter int WIDTH = 4,
  parameter int MAX_COUNT = 15,
  parameter int INIT = 0
) (
  input  logic             clk,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
`ifdef SYNCHRONOUS_COUNTER_GRAY_EN
  ,
  output logic [WIDTH-1:0] count_gray
`endif
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] INI = WIDTH'(INIT);
  logic [WIDTH-1:0] nxt;
  assign tc = count == MAX;
  // wrapping on tc keeps every value within 0..MAX_COUNT
  always_comb nxt = tc ? '0 : count + 1'b1;
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      count <= INI;
      wrap  <= 1'b0;
    end else begin
      count <= nxt;
      wrap  <= tc;
    end
`ifdef SYNCHRONOUS_COUNTER_GRAY_EN
  // encoding nxt lands the Gray value on the same edge as count
  always_ff @(posedge clk or negedge clr)
    if (!clr) count_gray <= INI ^ (INI >> 1);
    else count_gray <= nxt ^ (nxt >> 1);
`endif
endmodule

// File: tb/tb_synchronous_counter.sv
// tb_synchronous_counter: scoreboard bench for three parameterisations of synchronous_counter.
module tb_synchronous_counter;
  localparam int IN[3] = '{0, 0, 5};
  localparam int MX[3] = '{15, 9, 12};
  typedef struct packed {
    logic [2:0][3:0] c;
    logic [2:0] t;
    logic [2:0] w;
    logic step;
  } exp_t;
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic [3:0] cnt0, cnt1, cnt2;
  logic tc0, tc1, tc2, wr0, wr1, wr2;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int n = 0;
  always #10 clk = ~clk;
`ifdef SYNCHRONOUS_COUNTER_GRAY_EN
  logic [3:0] cg, cg1, cg2;
  synchronous_counter u0 (.clk(clk), .clr(clr), .count(cnt0), .tc(tc0), .wrap(wr0), .count_gray(cg));
  synchronous_counter #(.MAX_COUNT(9)) u1 (.clk(clk), .clr(clr), .count(cnt1), .tc(tc1), .wrap(wr1), .count_gray(cg1));
  synchronous_counter #(.INIT(5), .MAX_COUNT(12)) u2 (.clk(clk), .clr(clr), .count(cnt2), .tc(tc2), .wrap(wr2), .count_gray(cg2));
`else
  synchronous_counter u0 (.clk(clk), .clr(clr), .count(cnt0), .tc(tc0), .wrap(wr0));
  synchronous_counter #(.MAX_COUNT(9)) u1 (.clk(clk), .clr(clr), .count(cnt1), .tc(tc1), .wrap(wr1));
  synchronous_counter #(.INIT(5), .MAX_COUNT(12)) u2 (.clk(clk), .clr(clr), .count(cnt2), .tc(tc2), .wrap(wr2));
`endif
  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask
  // reference: n edges after release the count is (INIT + n) mod (MAX_COUNT + 1)
  task automatic push(input bit step);
    exp_t e;
    int v;
    for (int k = 0; k < 3; k++) begin
      v = (IN[k] + n) % (MX[k] + 1);
      e.c[k] = 4'(v);
      e.t[k] = v == MX[k];
      e.w[k] = clr && n > 0 && v == 0;
    end
    e.step = step;
    q.push_back(e);
  endtask
  task automatic cyc(input bit nc);
    bit step;
    bit fall;
    @(posedge clk);
    #2;
    step = clr;
    if (clr) n++;
    fall = clr && !nc;
    clr = nc;
    if (!nc) begin
      n = 0;
      step = 0;
    end
    if (fall) begin
      #1;
      chk("async_clr_count0", cnt0, IN[0]);
      chk("async_clr_count1", cnt1, IN[1]);
      chk("async_clr_count2", cnt2, IN[2]);
      chk("async_clr_wrap", {wr2, wr1, wr0}, 0);
    end
    push(step);
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      logic [2:0][3:0] ac;
      e = q.pop_front();
      ac = {cnt2, cnt1, cnt0};
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("count%0d", k), ac[k], e.c[k]);
        chk($sformatf("tc%0d", k), {tc2, tc1, tc0} >> k & 1, e.t[k]);
        chk($sformatf("wrap%0d", k), {wr2, wr1, wr0} >> k & 1, e.w[k]);
      end
`ifdef SYNCHRONOUS_COUNTER_GRAY_EN
      begin
        logic [3:0] g;
        logic [3:0] pg;
        g = e.c[0] ^ (e.c[0] >> 1);
        chk("gray", cg, g);
        chk("gray1", cg1, e.c[1] ^ (e.c[1] >> 1));
        chk("gray2", cg2, e.c[2] ^ (e.c[2] >> 1));
        pg = 4'(((IN[0] + n + 15) % 16) ^ (((IN[0] + n + 15) % 16) >> 1));
        if (e.step) chk("gray_one_bit", $countones(g ^ pg), 1);
      end
`endif
    end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (20) cyc(0);
    repeat (40) cyc(1);
    while ((n + 1) % 16 != 7) cyc(1);
    cyc(0);
    repeat (3) cyc(0);
    repeat (8) cyc(1);
    for (int i = 0; i < 400; i++)
      cyc(clr ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 1) == 1));
    repeat (40) cyc(1);
    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/synchronous_counter.md
SYNCHRONOUS_COUNTER -- requirements
Module: synchronous_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..16.
REQ-002 Parameter MAX_COUNT, default 15: highest count value before wrap; legal range 1..2^WIDTH-1.
REQ-003 Parameter INIT, default 0: value loaded by reset; legal range 0..MAX_COUNT.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port clr, input, 1: reset, asynchronous, active-low.
REQ-006 Port count, output, WIDTH: current count value, registered.
REQ-007 Port tc, output, 1: terminal count; combinational, high while count == MAX_COUNT.
REQ-008 Port wrap, output, 1: registered one-cycle pulse, high in the cycle after count wraps from MAX_COUNT to 0.
REQ-009 Only clk and clr are inputs; the block is free-running, and unused outputs may be left unconnected.

Function
REQ-010 While clr is high, count shall increment by 1 on every rising clk edge.
REQ-011 When count == MAX_COUNT at a rising edge, count shall become 0 on that edge (modulo MAX_COUNT+1).
REQ-012 With MAX_COUNT = 2^WIDTH-1, the wrap shall be natural binary roll-over (e.g. 4'hF -> 4'h0).
REQ-013 Latency: a change on count is visible one clk edge after the edge that caused it; there is no combinational path from clk or clr to count other than the reset clear.
REQ-014 tc shall be asserted for exactly one clock period per count cycle, coincident with count == MAX_COUNT.
REQ-015 wrap shall be set on the edge where count goes MAX_COUNT -> 0 and cleared on the following edge; it is never high for two consecutive cycles unless MAX_COUNT == 0, which is illegal.
REQ-016 Count arithmetic is unsigned WIDTH-bit; no intermediate value shall exceed MAX_COUNT.

Reset
REQ-017 clr low shall immediately, without waiting for clk, force count = INIT and wrap = 0; tc follows count combinationally.
REQ-018 While clr is held low, outputs shall hold their reset values regardless of clk activity.
REQ-019 Reset deassertion is released synchronously into the count path: the first increment occurs on the first rising clk edge after clr goes high.
REQ-020 Reset asserted mid-count shall abandon the current value with no wrap pulse generated.

Configuration
REQ-021 Macro SYNCHRONOUS_COUNTER_GRAY_EN: when defined, add output port count_gray [WIDTH-1:0], a registered Gray-code encoding of the next binary count. It shall be updated on the same edge as count, so that count_gray == count ^ (count >> 1) at all times.
REQ-022 count_gray shall reset to INIT ^ (INIT >> 1).
REQ-023 When the macro is not defined, the count_gray port and its logic shall be absent; all other behaviour is unchanged.
REQ-024 With the macro defined and MAX_COUNT = 2^WIDTH-1, consecutive count_gray values, including across the wrap, shall differ in exactly one bit.

Verification
REQ-025 Scenario: clr held 0 for 20 clk periods (10 ns half-period) -> count = 0, tc = 0, wrap = 0 throughout.
REQ-026 Scenario: defaults, release clr, run 16 edges -> count steps 0,1,...,15 then 0; tc high only at 15; wrap high for the one cycle after 15 -> 0.
REQ-027 Scenario: MAX_COUNT = 9 -> count sequence 0..9,0; tc at 9; wrap pulse every 10 edges.
REQ-028 Scenario: assert clr at count = 7, between clk edges -> count = INIT immediately; on release the next edge gives INIT+1; no wrap pulse.
REQ-029 Scenario: INIT = 5, MAX_COUNT = 12 -> after reset release the sequence is 5,6,...,12,0,1; tc at 12.
REQ-030 Scenario: SYNCHRONOUS_COUNTER_GRAY_EN defined, defaults, 32 edges -> count_gray == count ^ (count >> 1) every cycle, with a single-bit change per edge, including 4'b1000 -> 4'b0000.
